// File: rtl/dpc_pkg.sv
// Shared types and default parameters for the dual-channel pulse counter.
package dpc_pkg;
    localparam int CNT_W_DEF      = 8;
    localparam int STABLE_CYC_DEF = 2;
    localparam int WINDOW_DEF     = 16;

    typedef enum logic {
        RPT_IDLE = 1'b0,
        RPT_HOLD = 1'b1
    } rpt_state_t;
endpackage

// File: rtl/dual_pulse_counter_pulse_filter.sv
// One channel: input register, glitch filter, rise detect and saturating rise counter.
module pulse_filter
    import dpc_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             din,
    input  logic             restart,
    output logic             level,
    output logic [CNT_W-1:0] snap_cnt,
    output logic             snap_ovf
);
    localparam int STAB_W = $clog2(STABLE_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);

    logic             samp;
    logic [STAB_W-1:0] stab;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             settle;
    logic             rise;

    assign settle = (samp != level) && (stab == STAB_LAST);
    assign rise   = settle && samp;

    // Count including a rise on this edge, so the window-end snapshot sees it.
    always_comb begin
        snap_cnt = cnt;
        snap_ovf = ovf;
        if (rise) begin
            if (cnt == {CNT_W{1'b1}}) begin
                snap_ovf = 1'b1;
            end else begin
                snap_cnt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            samp  <= 1'b0;
            stab  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            samp <= din;
            if (samp == level) begin
                stab <= '0;
            end else if (settle) begin
                level <= samp;
                stab  <= '0;
            end else begin
                stab <= stab + STAB_W'(1);
            end
            if (restart) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                cnt <= snap_cnt;
                ovf <= snap_ovf;
            end
        end
    end
endmodule

// File: rtl/dual_pulse_counter.sv
// Two filtered rise counters sharing a measurement window, with a held snapshot report.
//  state    | meaning
//  RPT_IDLE | no unconsumed report; next window end loads one
//  RPT_HOLD | report_valid=1, snapshot held until accepted
module dual_pulse_counter
    import dpc_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF,
    parameter int WINDOW     = WINDOW_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             clear,
    output logic             level_a,
    output logic             level_b,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [CNT_W-1:0] report_cnt_a,
    output logic [CNT_W-1:0] report_cnt_b,
    output logic             report_ovf_a,
    output logic             report_ovf_b,
    output logic             overrun
);
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    logic [WIN_W-1:0] wcnt;
    logic             win_end;
    logic             restart;
    logic [CNT_W-1:0] snap_cnt_a, snap_cnt_b;
    logic             snap_ovf_a, snap_ovf_b;
    rpt_state_t       state, state_next;
    logic             load;
    logic             set_ovr;

    assign win_end      = (wcnt == WIN_LAST);
    assign restart      = win_end || clear;
    assign report_valid = (state == RPT_HOLD);

    pulse_filter #(.CNT_W(CNT_W), .STABLE_CYC(STABLE_CYC)) u_chan_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .din      (in_a),
        .restart  (restart),
        .level    (level_a),
        .snap_cnt (snap_cnt_a),
        .snap_ovf (snap_ovf_a)
    );

    pulse_filter #(.CNT_W(CNT_W), .STABLE_CYC(STABLE_CYC)) u_chan_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .din      (in_b),
        .restart  (restart),
        .level    (level_b),
        .snap_cnt (snap_cnt_b),
        .snap_ovf (snap_ovf_b)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        set_ovr    = 1'b0;
        case (state)
            RPT_IDLE: begin
                if (win_end) begin
                    load       = 1'b1;
                    state_next = RPT_HOLD;
                end
            end
            RPT_HOLD: begin
                if (win_end) begin
                    if (report_ready) load = 1'b1;
                    else              set_ovr = 1'b1;
                end else if (report_ready) begin
                    state_next = RPT_IDLE;
                end
            end
            default: state_next = RPT_IDLE;
        endcase
        if (clear) begin
            state_next = RPT_IDLE;
            load       = 1'b0;
            set_ovr    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= RPT_IDLE;
            wcnt         <= '0;
            report_cnt_a <= '0;
            report_cnt_b <= '0;
            report_ovf_a <= 1'b0;
            report_ovf_b <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= state_next;
            wcnt  <= restart ? '0 : wcnt + WIN_W'(1);
            if (clear) begin
                report_cnt_a <= '0;
                report_cnt_b <= '0;
                report_ovf_a <= 1'b0;
                report_ovf_b <= 1'b0;
                overrun      <= 1'b0;
            end else begin
                if (load) begin
                    report_cnt_a <= snap_cnt_a;
                    report_cnt_b <= snap_cnt_b;
                    report_ovf_a <= snap_ovf_a;
                    report_ovf_b <= snap_ovf_b;
                end
                if (set_ovr) overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dual_pulse_counter.sv
// Bench: directed and random stimulus on two instances (default and narrow-counter/long-window).
module tb_dual_pulse_counter;
    localparam int S  = 2;
    localparam int W0 = 16;
    localparam int W1 = 64;

    logic clock = 1'b0;
    logic reset_n = 1'b0, in_a = 1'b0, in_b = 1'b0, clear = 1'b0, report_ready = 1'b0;

    logic       la0, lb0, rv0, roa0, rob0, ov0;
    logic [7:0] rca0, rcb0;
    logic       la1, lb1, rv1, roa1, rob1, ov1;
    logic [1:0] rca1, rcb1;

    always #5 clock = ~clock;

    dual_pulse_counter dut0 (
        .clock(clock), .reset_n(reset_n), .in_a(in_a), .in_b(in_b), .clear(clear),
        .level_a(la0), .level_b(lb0), .report_valid(rv0), .report_ready(report_ready),
        .report_cnt_a(rca0), .report_cnt_b(rcb0), .report_ovf_a(roa0), .report_ovf_b(rob0),
        .overrun(ov0)
    );

    dual_pulse_counter #(.CNT_W(2), .STABLE_CYC(S), .WINDOW(W1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_a(in_a), .in_b(in_b), .clear(clear),
        .level_a(la1), .level_b(lb1), .report_valid(rv1), .report_ready(report_ready),
        .report_cnt_a(rca1), .report_cnt_b(rcb1), .report_ovf_a(roa1), .report_ovf_b(rob1),
        .overrun(ov1)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: level follows the last S sampled values; counts per window.
    bit m_ra, m_rb, m_la, m_lb;
    bit ha[$];
    bit hb[$];
    int wmax[2] = '{W0, W1};
    int cmax[2] = '{255, 3};
    int wc[2], ca[2], cb[2], rca[2], rcb[2];
    bit oa[2], ob[2], vld[2], roa[2], rob[2], ovr[2];

    bit cur_a = 0, cur_b = 0, cur_rdy = 0;

    function automatic bit settles(input bit q[$], input bit lvl);
        if (q.size() < S) return 1'b0;
        foreach (q[i]) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit a, input bit b, input bit rdy, input bit clr, input bit rst);
        bit fa, fb, rise_a, rise_b, soa, sob;
        int sa, sb;
        if (!rst) begin
            m_ra = 0; m_rb = 0; m_la = 0; m_lb = 0;
            ha.delete(); hb.delete();
            for (int k = 0; k < 2; k++) begin
                wc[k] = 0; ca[k] = 0; cb[k] = 0; oa[k] = 0; ob[k] = 0;
                vld[k] = 0; rca[k] = 0; rcb[k] = 0; roa[k] = 0; rob[k] = 0; ovr[k] = 0;
            end
        end else begin
            ha.push_back(m_ra); if (ha.size() > S) void'(ha.pop_front());
            hb.push_back(m_rb); if (hb.size() > S) void'(hb.pop_front());
            m_ra = a; m_rb = b;
            fa = settles(ha, m_la); fb = settles(hb, m_lb);
            rise_a = fa && !m_la; rise_b = fb && !m_lb;
            for (int k = 0; k < 2; k++) begin
                sa = ca[k]; soa = oa[k]; sb = cb[k]; sob = ob[k];
                if (rise_a) begin if (sa == cmax[k]) soa = 1; else sa++; end
                if (rise_b) begin if (sb == cmax[k]) sob = 1; else sb++; end
                if (clr) begin
                    wc[k] = 0; ca[k] = 0; cb[k] = 0; oa[k] = 0; ob[k] = 0;
                    vld[k] = 0; rca[k] = 0; rcb[k] = 0; roa[k] = 0; rob[k] = 0; ovr[k] = 0;
                end else if (wc[k] == wmax[k] - 1) begin
                    if (!vld[k] || rdy) begin
                        vld[k] = 1; rca[k] = sa; rcb[k] = sb; roa[k] = soa; rob[k] = sob;
                    end else begin
                        ovr[k] = 1;
                    end
                    wc[k] = 0; ca[k] = 0; cb[k] = 0; oa[k] = 0; ob[k] = 0;
                end else begin
                    if (vld[k] && rdy) vld[k] = 0;
                    ca[k] = sa; cb[k] = sb; oa[k] = soa; ob[k] = sob;
                    wc[k]++;
                end
            end
            if (fa) m_la = !m_la;
            if (fb) m_lb = !m_lb;
        end
    endtask

    task automatic compare();
        chk("level_a0", int'(la0), int'(m_la));
        chk("level_b0", int'(lb0), int'(m_lb));
        chk("level_a1", int'(la1), int'(m_la));
        chk("level_b1", int'(lb1), int'(m_lb));
        chk("valid0", int'(rv0), int'(vld[0]));
        chk("cnt_a0", int'(rca0), rca[0]);
        chk("cnt_b0", int'(rcb0), rcb[0]);
        chk("ovf_a0", int'(roa0), int'(roa[0]));
        chk("ovf_b0", int'(rob0), int'(rob[0]));
        chk("overrun0", int'(ov0), int'(ovr[0]));
        chk("valid1", int'(rv1), int'(vld[1]));
        chk("cnt_a1", int'(rca1), rca[1]);
        chk("cnt_b1", int'(rcb1), rcb[1]);
        chk("ovf_a1", int'(roa1), int'(roa[1]));
        chk("ovf_b1", int'(rob1), int'(rob[1]));
        chk("overrun1", int'(ov1), int'(ovr[1]));
    endtask

    task automatic step(input bit clr, input bit rst);
        @(negedge clock);
        in_a = cur_a; in_b = cur_b; report_ready = cur_rdy; clear = clr; reset_n = rst;
        @(posedge clock);
        model_edge(cur_a, cur_b, cur_rdy, clr, rst);
        #1;
        compare();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        int run_a, run_b;
        // reset with in_a held high; the first report must carry exactly one A rise
        cur_a = 1; cur_rdy = 0;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        chk("rst_valid", int'(rv0), 0);
        tick(2);
        chk("lvl_a_edge2", int'(la0), 0);
        tick(1);
        chk("lvl_a_edge3", int'(la0), 1);
        tick(15);
        chk("first_rpt_a", int'(rca0), 1);
        chk("first_rpt_b", int'(rcb0), 0);
        cur_rdy = 1; tick(1); cur_rdy = 0;

        // glitch rejection, then minimal accepted pulse
        cur_a = 0; tick(6);
        cur_a = 1; tick(1); cur_a = 0; tick(6);
        cur_a = 1; tick(2); cur_a = 0; tick(6);

        // mixed counting
        cur_rdy = 1;
        repeat (3) begin cur_a = 1; tick(4); cur_a = 0; tick(4); end
        cur_b = 1; tick(4); cur_b = 0; tick(4);

        // saturation on the narrow-counter instance
        repeat (5) begin cur_b = 1; tick(2); cur_b = 0; tick(2); end
        tick(70);

        // backpressure across several window ends
        cur_rdy = 0; tick(40);
        cur_rdy = 1; tick(1);
        cur_rdy = 0; tick(20);
        cur_rdy = 1; tick(3);

        // clear landing on a window-end edge
        for (int i = 0; i < 20 && wc[0] != W0 - 1; i++) tick(1);
        chk("pre_clear_wc", wc[0], W0 - 1);
        step(1'b1, 1'b1);
        chk("clear_valid", int'(rv0), 0);
        chk("clear_overrun", int'(ov0), 0);
        tick(5);

        // reset while a report is pending
        cur_rdy = 0;
        for (int i = 0; i < 40 && !vld[0]; i++) tick(1);
        chk("pre_rst_valid", int'(rv0), 1);
        step(1'b0, 1'b0);
        chk("rst_mid_valid", int'(rv0), 0);
        chk("rst_mid_cnt_a", int'(rca0), 0);
        tick(3);

        // randomized traffic
        run_a = 0; run_b = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_a == 0) begin cur_a = ~cur_a; run_a = $urandom_range(1, 6); end
            if (run_b == 0) begin cur_b = ~cur_b; run_b = $urandom_range(1, 6); end
            run_a--; run_b--;
            cur_rdy = ($urandom % 4) != 0;
            step(($urandom % 200) == 0, ($urandom % 600) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
